hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the RV32I core: owns stall, flush and bubble control for the IF/ID and ID/EX
//  (decode_pipe) registers, and selects forwarding sources for EX operands.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_fwd_select.sv | 22 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller: FSM states, forwarding codes, NOP.
// Optional performance counters in hazard_ctrl are enabled with CTRL_PERF_CNT_EN.
package rv32i_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding source select for one EX operand; the younger EX/MEM result wins over MEM/WB.
module fwd_select
  import rv32i_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_reg_write && reg_match(i_mem_rd, i_rs)) begin
      o_sel = FWD_EXMEM;
    end else if (i_wb_reg_write && reg_match(i_wb_rd, i_rs)) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/bubble sequencer and EX forwarding select for the RV32I core.
// Define CTRL_PERF_CNT_EN to add the stall and redirect performance counters.
module hazard_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_load,
  input  logic       i_ex_redirect,
  input  logic [4:0] i_mem_rd,
  input  logic [4:0] i_wb_rd,
  input  logic       i_mem_reg_write,
  input  logic       i_wb_reg_write,
  input  logic       i_mem_access,
  input  logic       i_dmem_ready,
  output logic       o_stall_pc,
  output logic       o_stall_if_id,
  output logic       o_stall_id_ex,
  output logic       o_stall_ex_mem,
  output logic       o_flush_if_id,
  output logic       o_flush_id_ex,
  output logic [1:0] o_fwd_a_sel,
  output logic [1:0] o_fwd_b_sel
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  ctrl_state_e r_state;
  logic [3:0]  r_flush_cnt;

  logic       w_memwait;
  logic       w_load_use;
  logic       w_redirect_take;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_memwait       = i_mem_access & ~i_dmem_ready;
  assign w_load_use      = i_ex_load & (reg_match(i_ex_rd, i_id_rs1) | reg_match(i_ex_rd, i_id_rs2));
  assign w_redirect_take = ~i_rst & ~w_memwait & i_ex_redirect;

  always_comb begin
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    if (!i_rst) begin
      if (w_memwait) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
      end else begin
        // The cycle leaving MEMWAIT behaves like RUN; a pending flush resumes next cycle.
        o_flush_if_id = i_ex_redirect | (r_state == FLUSH);
        o_flush_id_ex = i_ex_redirect | w_load_use;
        o_stall_pc    = ~i_ex_redirect & w_load_use;
        o_stall_if_id = ~i_ex_redirect & w_load_use;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_flush_cnt <= 4'd0;
    end else if (w_memwait) begin
      r_state <= MEMWAIT;
    end else if (i_ex_redirect) begin
      r_flush_cnt <= FLUSH_RELOAD;
      r_state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      case (r_state)
        FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 4'd1;
          if (r_flush_cnt == 4'd1) r_state <= RUN;
        end
        MEMWAIT: r_state <= (r_flush_cnt != 4'd0) ? FLUSH : RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  fwd_select u_fwd_a (
    .i_rs            (i_ex_rs1),
    .i_mem_rd        (i_mem_rd),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_rd         (i_wb_rd),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_sel           (w_fwd_a)
  );

  fwd_select u_fwd_b (
    .i_rs            (i_ex_rs2),
    .i_mem_rd        (i_mem_rd),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_rd         (i_wb_rd),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_sel           (w_fwd_b)
  );

  assign o_fwd_a_sel = i_rst ? FWD_RF : w_fwd_a;
  assign o_fwd_b_sel = i_rst ? FWD_RF : w_fwd_b;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt_perf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt      <= '0;
      r_flush_cnt_perf <= '0;
    end else begin
      if (o_stall_pc)      r_stall_cnt      <= r_stall_cnt + 1'b1;
      if (w_redirect_take) r_flush_cnt_perf <= r_flush_cnt_perf + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt_perf;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized cycles against a pending-flush model.
module tb_hazard_ctrl;

  localparam int FC = 2;
  localparam int CW = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_load, ex_redirect, mem_reg_write, wb_reg_write, mem_access, dmem_ready;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef CTRL_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
    .i_ex_rd(ex_rd), .i_ex_load(ex_load), .i_ex_redirect(ex_redirect),
    .i_mem_rd(mem_rd), .i_wb_rd(wb_rd), .i_mem_reg_write(mem_reg_write),
    .i_wb_reg_write(wb_reg_write), .i_mem_access(mem_access), .i_dmem_ready(dmem_ready),
    .o_stall_pc(stall_pc), .o_stall_if_id(stall_if_id), .o_stall_id_ex(stall_id_ex),
    .o_stall_ex_mem(stall_ex_mem), .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex),
    .o_fwd_a_sel(fwd_a_sel), .o_fwd_b_sel(fwd_b_sel)
`ifdef CTRL_PERF_CNT_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: flush cycles still owed, and whether the previous cycle was a memory freeze.
  int m_pending = 0;
  bit m_frozen  = 1'b0;
  int m_stall_n = 0;
  int m_flush_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex};
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rst || rs == 5'd0) return 2'b00;
    if (mem_reg_write && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [5:0] ctl_ref();
    bit lu, fif, fex, st;
    if (rst) return 6'b0;
    if (mem_access && !dmem_ready) return 6'b111100;
    lu  = ex_load && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    fif = ex_redirect || (m_pending > 0 && !m_frozen);
    fex = ex_redirect || lu;
    st  = !ex_redirect && lu;
    return {st, st, 1'b0, 1'b0, fif, fex};
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_load = 0; ex_redirect = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_access = 0; dmem_ready = 1; rst = 0;
  endtask

  // Check the current cycle against the model, then advance one clock and update the model.
  task automatic step();
    logic [5:0] e;
    bit frz;
    #3;
    e = ctl_ref();
    check("ctl", 32'(ctl_now()), 32'(e));
    check("fwd_a", 32'(fwd_a_sel), 32'(fwd_ref(ex_rs1)));
    check("fwd_b", 32'(fwd_b_sel), 32'(fwd_ref(ex_rs2)));
`ifdef CTRL_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_n));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush_n));
`endif
    @(posedge clk);
    frz = mem_access && !dmem_ready;
    if (rst) begin
      m_pending = 0; m_frozen = 0; m_stall_n = 0; m_flush_n = 0;
    end else begin
      if (e[5]) m_stall_n = (m_stall_n + 1) % (1 << CW);
      if (frz) begin
        m_frozen = 1;
      end else begin
        if (ex_redirect) begin
          m_pending = FC - 1;
          m_flush_n = (m_flush_n + 1) % (1 << CW);
        end else if (m_pending > 0 && !m_frozen) begin
          m_pending--;
        end
        m_frozen = 0;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    #1 check("rst_ctl", 32'(ctl_now()), 32'h0);
    step();
    idle();
    step();

    // Load-use on rs2, then bubble; rd==x0 never stalls.
    ex_load = 1; ex_rd = 5; id_rs2 = 5;
    #1 check("lu_on", 32'({stall_pc, stall_if_id, flush_id_ex}), 32'b111);
    step();
    idle();
    #1 check("lu_off", 32'(ctl_now()), 32'h0);
    step();
    ex_load = 1; ex_rd = 0; id_rs1 = 0;
    #1 check("lu_x0", 32'(ctl_now()), 32'h0);
    step();
    idle();

    // Redirect: flush_if_id two cycles, flush_id_ex one.
    ex_redirect = 1;
    #1 check("rd_c0", 32'(ctl_now()), 32'b000011);
    step();
    idle();
    #1 check("rd_c1", 32'(ctl_now()), 32'b000010);
    step();
    #1 check("rd_c2", 32'(ctl_now()), 32'h0);
    step();

    // Freeze with a redirect pending; redirect flush comes on the ready cycle.
    for (int i = 0; i < 3; i++) begin
      mem_access = 1; dmem_ready = 0; ex_redirect = 1;
      #1 check("mw_frz", 32'(ctl_now()), 32'b111100);
      step();
    end
    dmem_ready = 1;
    #1 check("mw_rdy", 32'(ctl_now()), 32'b000011);
    step();
    idle();
    #1 check("mw_fl", 32'(ctl_now()), 32'b000010);
    step();
    #1 check("mw_end", 32'(ctl_now()), 32'h0);
    step();

    // Forwarding priority.
    mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 7;
    #1 check("fwd_exmem", 32'(fwd_a_sel), 32'b01);
    mem_reg_write = 0;
    #1 check("fwd_memwb", 32'(fwd_a_sel), 32'b10);
    ex_rs1 = 0;
    #1 check("fwd_x0", 32'(fwd_a_sel), 32'b00);
    step();
    idle();

    // Reset in the middle of a flush.
    ex_redirect = 1;
    step();
    idle(); rst = 1; ex_rs1 = 3; mem_rd = 3; mem_reg_write = 1;
    #1 check("rstfl_ctl", 32'(ctl_now()), 32'h0);
    check("rstfl_fwd", 32'(fwd_a_sel), 32'h0);
    step();
    idle();
    #1 check("rstfl_run", 32'(ctl_now()), 32'h0);
    step();

`ifdef CTRL_PERF_CNT_EN
    rst = 1; step(); idle();
    ex_load = 1; ex_rd = 4; id_rs1 = 4; step(); idle();
    ex_redirect = 1; step(); idle();
    step(); step();
    check("perf_stall", 32'(stall_cnt), 32'd1);
    check("perf_flush", 32'(flush_cnt), 32'd1);
`endif

    // Randomized traffic on a small register range so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_rs1        = 5'($urandom_range(0, 3));
      ex_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      ex_load       = $urandom_range(0, 1);
      ex_redirect   = ($urandom_range(0, 4) == 0);
      mem_reg_write = $urandom_range(0, 1);
      wb_reg_write  = $urandom_range(0, 1);
      mem_access    = ($urandom_range(0, 2) == 0);
      dmem_ready    = $urandom_range(0, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
